// File: rtl/iterative_shifter_pkg.sv
// Shared encodings for the iterative shifter: shift kinds, FSM states, default width.
// ITER_SHIFTER_ROTATE_EN (optional) enables the ROL kind in shift_step.
package iterative_shifter_pkg;

  localparam int WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    KIND_SLL = 2'b00,
    KIND_SRL = 2'b01,
    KIND_SRA = 2'b10,
    KIND_ROL = 2'b11
  } kind_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/iterative_shifter_shift_step.sv
// Combinational single-position shift of one word by the latched kind.
// Macro ITER_SHIFTER_ROTATE_EN: when undefined, KIND_ROL decodes as SLL and no rotate path exists.
module shift_step
  import iterative_shifter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] word,
  input  kind_e            kind,
  output logic [WIDTH-1:0] shifted,
  output logic             shifted_out
);

  always_comb begin
    shifted     = {word[WIDTH-2:0], 1'b0};
    shifted_out = word[WIDTH-1];
    case (kind)
      KIND_SRL: begin
        shifted     = {1'b0, word[WIDTH-1:1]};
        shifted_out = word[0];
      end
      KIND_SRA: begin
        shifted     = {word[WIDTH-1], word[WIDTH-1:1]};
        shifted_out = word[0];
      end
`ifdef ITER_SHIFTER_ROTATE_EN
      KIND_ROL: begin
        shifted     = {word[WIDTH-2:0], word[WIDTH-1]};
        shifted_out = word[WIDTH-1];
      end
`endif
      default: begin
        shifted     = {word[WIDTH-2:0], 1'b0};
        shifted_out = word[WIDTH-1];
      end
    endcase
  end

endmodule

// File: rtl/iterative_shifter.sv
// Multi-cycle shifter: one single-position step per clock with a busy/done handshake.
// Optional ROL support is selected by ITER_SHIFTER_ROTATE_EN inside shift_step.
module iterative_shifter
  import iterative_shifter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  input  logic [AMT_W-1:0] amount,
  input  logic [1:0]       kind,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out
);

  state_e           state;
  logic [WIDTH-1:0] work;
  logic [AMT_W-1:0] count;
  kind_e            kind_q;
  logic [WIDTH-1:0] step_word;
  logic             step_out;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .word        (work),
    .kind        (kind_q),
    .shifted     (step_word),
    .shifted_out (step_out)
  );

  // The working word and latched kind are pure data and carry no reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      count     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            work      <= data_in;
            count     <= amount;
            kind_q    <= kind_e'(kind);
            carry_out <= 1'b0;
            busy      <= 1'b1;
            if (amount == '0) begin
              result <= data_in;
              done   <= 1'b1;
              state  <= ST_DONE;
            end else begin
              state  <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          work      <= step_word;
          carry_out <= step_out;
          count     <= count - AMT_W'(1);
          // Result is published only on the final step so it stays stable until the next start.
          if (count == AMT_W'(1)) begin
            result <= step_word;
            done   <= 1'b1;
            state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iterative_shifter.sv
// Self-checking bench for iterative_shifter: directed cases plus random operations vs. an arithmetic model.
// The model follows ITER_SHIFTER_ROTATE_EN the same way the design build does.
module tb_iterative_shifter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] data_in;
  logic [3:0]  amount;
  logic [1:0]  kind;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        carry_out;

  int n_cmp = 0;
  int n_bad = 0;

  iterative_shifter dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .data_in   (data_in),
    .amount    (amount),
    .kind      (kind),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Whole-amount shift computed directly from the shift definitions.
  function automatic void model(input logic [15:0] d, input int a, input logic [1:0] k,
                                output logic [15:0] r, output logic c);
    logic [1:0] kk;
    kk = k;
`ifndef ITER_SHIFTER_ROTATE_EN
    if (kk == 2'b11) kk = 2'b00;
`endif
    r = d;
    c = 1'b0;
    case (kk)
      2'b00: begin r = d << a;                     if (a > 0) c = d[16-a]; end
      2'b01: begin r = d >> a;                     if (a > 0) c = d[a-1];  end
      2'b10: begin r = 16'($signed(d) >>> a);      if (a > 0) c = d[a-1];  end
      default: begin r = (d << a) | (d >> (16-a)); if (a > 0) c = r[0];    end
    endcase
  endfunction

  task automatic run_op(input logic [15:0] d, input logic [3:0] a, input logic [1:0] k, input bit poke);
    logic [15:0] er;
    logic        ec;
    int          cyc;
    model(d, int'(a), k, er, ec);
    @(negedge clk);
    start = 1'b1; data_in = d; amount = a; kind = k;
    @(negedge clk);
    start = poke; data_in = 16'($urandom); amount = 4'($urandom); kind = 2'($urandom);
    cyc = 1;
    while (done !== 1'b1 && cyc < 40) begin
      chk("busy_during", 32'(busy), 32'd1);
      @(negedge clk);
      cyc++;
    end
    chk("latency", 32'(cyc), 32'(a) + 32'd1);
    chk("busy_at_done", 32'(busy), 32'd1);
    chk("result", 32'(result), 32'(er));
    chk("carry", 32'(carry_out), 32'(ec));
    @(negedge clk);
    start = 1'b0;
    chk("done_pulse_len", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("result_hold", 32'(result), 32'(er));
    chk("carry_hold", 32'(carry_out), 32'(ec));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; data_in = '0; amount = '0; kind = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_carry", 32'(carry_out), 32'd0);
    rst = 1'b0;

    run_op(16'h0001, 4'd1, 2'b00, 1'b0);
    run_op(16'hFFFF, 4'd1, 2'b00, 1'b0);
    run_op(16'h8000, 4'd15, 2'b10, 1'b0);
    run_op(16'h8000, 4'd15, 2'b01, 1'b0);
    run_op(16'h1234, 4'd0, 2'b00, 1'b1);
    run_op(16'hABCD, 4'd5, 2'b01, 1'b1);
    run_op(16'h8001, 4'd4, 2'b11, 1'b0);

    // Reset in the middle of a shift aborts it with no done pulse.
    @(negedge clk);
    start = 1'b1; data_in = 16'h00FF; amount = 4'd8; kind = 2'b00;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_abort_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_carry", 32'(carry_out), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("abort_no_done", 32'(done), 32'd0);
    end
    run_op(16'h00FF, 4'd8, 2'b00, 1'b0);

    for (int i = 0; i < 40; i++)
      run_op(16'($urandom), 4'($urandom), 2'($urandom), 1'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
